// File: rtl/fifo_tx_drain.sv
// FIFO-fed 8N1 serial transmitter. It pops one byte at a time from an external
// FIFO and shifts it out LSB first. Every output comes straight from a flop.
module fifo_tx_drain #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       empty,
  input  logic [7:0] dataOut,
  output logic       dequeue,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  // Outputs are assigned for the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      dequeue  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      dequeue <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state   <= POP;
            dequeue <= 1'b1;
            busy    <= 1'b1;
          end
        end
        POP: state <= LOAD;
        LOAD: begin
          shift    <= dataOut;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // shift[1] is the bit that moves into shift[0] on this edge
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            // Raise tx_done one cycle early so the registered pulse lands on the last stop cycle.
            if (baud_cnt == BAUD_PRE) tx_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_tx_drain.md
FIFO_TX_DRAIN -- requirements
Module: fifo_tx_drain

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit; legal range is 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port empty, input, 1 bit: the FIFO empty flag.
REQ-006 The block SHALL have port dataOut, input, 8 bits: FIFO read data, valid on the cycle after the cycle dequeue is sampled high.
REQ-007 The block SHALL have port dequeue, output, 1 bit: FIFO pop strobe, one cycle per byte.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, idle high, 8N1 framing, LSB first.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 The FSM SHALL have exactly these states: IDLE, POP, LOAD, START, DATA, STOP.
REQ-012 IDLE: if empty==0, the FSM SHALL go to POP; otherwise it SHALL stay in IDLE.
REQ-013 POP: dequeue SHALL be high for exactly this one cycle, and the FSM SHALL go to LOAD.
REQ-014 LOAD: the FSM SHALL capture dataOut into an 8-bit shift register, clear the bit counter and baud counter, and go to START.
REQ-015 START: tx SHALL be 0 for CLKS_PER_BIT cycles, then the FSM SHALL go to DATA.
REQ-016 DATA: tx SHALL be shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; after 8 bits the FSM SHALL go to STOP.
REQ-017 STOP: tx SHALL be 1 for CLKS_PER_BIT cycles; on the last cycle tx_done SHALL be 1; the FSM SHALL then go to IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-019 Latency from IDLE with empty==0 to the first START cycle SHALL be 3 cycles: IDLE, POP, LOAD.
REQ-020 Back-to-back frames: with empty==0 throughout, the gap between frames SHALL be exactly 3 idle-high cycles (IDLE, POP, LOAD).
REQ-021 dequeue SHALL never be asserted while empty==1 is sampled in the same cycle decision, and SHALL never be asserted outside POP.
REQ-022 empty changing during START, DATA or STOP SHALL be ignored until the FSM returns to IDLE.
REQ-023 tx SHALL be driven from a register and SHALL be glitch-free; tx SHALL be 1 in IDLE, POP and LOAD.
REQ-024 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-025 The bit counter SHALL be 3 bits wide and count 0..7.

Reset
REQ-026 While rst_n==0, the block SHALL force state=IDLE, tx=1, dequeue=0, busy=0, tx_done=0, and all counters and the shift register to 0, asynchronously.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with tx=1; the popped byte SHALL be lost and SHALL NOT be re-requested.
REQ-028 After rst_n deasserts, the first possible dequeue SHALL occur on the second rising edge, one cycle in IDLE.

Verification (CLKS_PER_BIT=4)
REQ-029 The bench SHALL cover single byte: FIFO holds 0xF0 -> one dequeue pulse; tx = 0 (start), then 0,0,0,0,1,1,1,1, then 1 (stop), each held 4 cycles; tx_done pulses once at cycle 40 of the frame.
REQ-030 The bench SHALL cover a three-byte burst: enqueue 0xF0, 0x0F, 0x01 -> exactly three dequeue pulses, three frames in order, 3-cycle high gaps between frames, and busy low after the last stop bit.
REQ-031 The bench SHALL cover empty FIFO: empty==1 for 100 cycles -> dequeue=0, tx=1, busy=0 throughout.
REQ-032 The bench SHALL cover mid-frame reset: rst_n low during the DATA bit 3 of 0xA5 -> tx=1 and busy=0 in the same cycle; after release with the FIFO holding 0x3C, the next frame carries 0x3C.
REQ-033 The bench SHALL cover late data: empty deasserts during STOP of the previous frame -> no dequeue until IDLE, then POP on the cycle after STOP ends.
REQ-034 The bench SHALL cover the minimum divider: CLKS_PER_BIT=2 with byte 0x55 -> frame of 20 cycles with alternating bits 1,0,1,0,1,0,1,0 after the start bit.
